// File: rtl/pipe_stage_ctrl_pkg.sv
// ============================================================================
// pipe_stage_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the MIPS pipeline-stage control register:
//   - opcode / funct constants for the instructions the core understands
//   - ALU operation codes carried down the pipe (alu_op_e)
//   - Tnew constants used by the hazard unit
//   - one-hot instruction flag struct produced by pipe_instr_decode
//   - helper functions turning flags into ALU controls
// No ports; imported by pipe_instr_decode and pipe_stage_ctrl.
// ============================================================================
package pipe_stage_ctrl_pkg;

    // ------------------------------------------------------------------
    // Primary opcodes (instr[31:26])
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_SPECIAL = 6'h00;  // R-type, function in funct
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // ------------------------------------------------------------------
    // SPECIAL funct codes (instr[5:0])
    // ------------------------------------------------------------------
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ------------------------------------------------------------------
    // ALU operation codes. ALU_ADDU must stay 0: it is both the reset
    // value and the bubble value of the registered control.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ALU_ADDU = 3'd0,
        ALU_SUBU = 3'd1,
        ALU_OR   = 3'd2,
        ALU_LUI  = 3'd3
    } alu_op_e;

    // ------------------------------------------------------------------
    // Tnew: cycles from the D stage until the result can be forwarded
    // ------------------------------------------------------------------
    localparam logic [1:0] T_PC  = 2'd0;
    localparam logic [1:0] T_ALU = 2'd1;
    localparam logic [1:0] T_DM  = 2'd2;

    // ------------------------------------------------------------------
    // One-hot instruction flags. All zero for an unknown encoding, which
    // makes unknown instructions behave as NOPs downstream.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic mult;
        logic multu;
        logic div;
        logic divu;
    } instr_flags_t;

    // ALU operation for a decoded instruction (ADDU when nothing special).
    function automatic alu_op_e decode_alu_ctr(input instr_flags_t f);
        alu_op_e r;
        r = ALU_ADDU;
        if (f.subu)     r = ALU_SUBU;
        else if (f.ori) r = ALU_OR;
        else if (f.lui) r = ALU_LUI;
        return r;
    endfunction

    // Second ALU operand comes from the immediate field.
    function automatic logic decode_alu_src(input instr_flags_t f);
        return f.ori | f.lw | f.sw | f.lui;
    endfunction

    // Instruction occupies the multiply/divide unit.
    function automatic logic decode_is_mdu(input instr_flags_t f);
        return f.mult | f.multu | f.div | f.divu;
    endfunction

endpackage

// File: rtl/pipe_instr_decode.sv
// ============================================================================
// pipe_instr_decode
// ----------------------------------------------------------------------------
// Purely combinational opcode/funct decoder producing one-hot instruction
// flags (instr_flags_t). Encodings that match nothing produce all-zero flags.
//
// Parameters:
//   OPW    opcode width
//   FUNCW  funct width
// Ports:
//   i_op     in   OPW     opcode
//   i_func   in   FUNCW   funct (only meaningful for SPECIAL opcode)
//   o_flags  out  struct  one-hot instruction flags
// ============================================================================
module pipe_instr_decode
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int FUNCW = 6
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [FUNCW-1:0] i_func,
    output instr_flags_t     o_flags
);

    logic w_special;

    assign w_special = (i_op == OPW'(OP_SPECIAL));

    // R-type instructions need both the SPECIAL opcode and the funct match
    assign o_flags.addu  = w_special && (i_func == FUNCW'(FN_ADDU));
    assign o_flags.subu  = w_special && (i_func == FUNCW'(FN_SUBU));
    assign o_flags.jr    = w_special && (i_func == FUNCW'(FN_JR));
    assign o_flags.mult  = w_special && (i_func == FUNCW'(FN_MULT));
    assign o_flags.multu = w_special && (i_func == FUNCW'(FN_MULTU));
    assign o_flags.div   = w_special && (i_func == FUNCW'(FN_DIV));
    assign o_flags.divu  = w_special && (i_func == FUNCW'(FN_DIVU));

    // I/J-type instructions are identified by opcode alone
    assign o_flags.ori   = (i_op == OPW'(OP_ORI));
    assign o_flags.lui   = (i_op == OPW'(OP_LUI));
    assign o_flags.lw    = (i_op == OPW'(OP_LW));
    assign o_flags.sw    = (i_op == OPW'(OP_SW));
    assign o_flags.beq   = (i_op == OPW'(OP_BEQ));
    assign o_flags.j     = (i_op == OPW'(OP_J));
    assign o_flags.jal   = (i_op == OPW'(OP_JAL));

endmodule

// File: rtl/pipe_stage_ctrl.sv
// ============================================================================
// pipe_stage_ctrl
// ----------------------------------------------------------------------------
// Control pipeline register for one stage boundary (D/E, E/M or M/W) of the
// 5-stage MIPS core. Latches op/funct, destination and write enable,
// registers decoded ALU controls, and tracks Tnew for forwarding. Supports
// stall-hold, flush-to-bubble and a per-stage Tnew decrement.
//
// Edge priority: flush > stall > load.
//
// Build option:
//   PIPE_STAGE_MDU_BUSY_EN  defined   -> multiply/divide busy counter
//                           undefined -> mdu_busy tied to 0
//
// Parameters:
//   OPW, FUNCW, RAW, TW  field widths
//   TDEC                 subtracted (saturating) from tnew_in on load
//   MDU_LAT              mult/div busy cycles (busy counter build only)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   stall      in   1      hold all stage contents
//   flush      in   1      load a bubble
//   valid_in   in   1      upstream slot holds a real instruction
//   op_in      in   OPW    opcode
//   func_in    in   FUNCW  funct
//   waddr_in   in   RAW    destination register
//   regwr_in   in   1      register write enable
//   tnew_in    in   TW     Tnew at the upstream stage
//   valid_out  out  1      registered valid
//   op_out     out  OPW    registered opcode
//   func_out   out  FUNCW  registered funct
//   waddr_out  out  RAW    registered destination
//   regwr_out  out  1      registered write enable (never 1 for $0)
//   tnew_out   out  TW     cycles until result available
//   alu_src    out  1      immediate operand select
//   alu_ctr    out  3      ALU operation code
//   fwd_ready  out  1      valid & regwr & tnew==0 (combinational)
//   mdu_busy   out  1      multiply/divide unit busy
// ============================================================================
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int FUNCW   = 6,
    parameter int RAW     = 5,
    parameter int TW      = 2,
    parameter int TDEC    = 1,
    parameter int MDU_LAT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [OPW-1:0]   op_in,
    input  logic [FUNCW-1:0] func_in,
    input  logic [RAW-1:0]   waddr_in,
    input  logic             regwr_in,
    input  logic [TW-1:0]    tnew_in,
    output logic             valid_out,
    output logic [OPW-1:0]   op_out,
    output logic [FUNCW-1:0] func_out,
    output logic [RAW-1:0]   waddr_out,
    output logic             regwr_out,
    output logic [TW-1:0]    tnew_out,
    output logic             alu_src,
    output logic [2:0]       alu_ctr,
    output logic             fwd_ready,
    output logic             mdu_busy
);

    localparam logic [TW-1:0] TDEC_W = TW'(TDEC);

    // ------------------------------------------------------------------
    // Input-side decode
    // ------------------------------------------------------------------
    instr_flags_t w_flags;

    pipe_instr_decode #(
        .OPW   (OPW),
        .FUNCW (FUNCW)
    ) u_decode (
        .i_op    (op_in),
        .i_func  (func_in),
        .o_flags (w_flags)
    );

    logic            w_load;
    logic            w_regwr;
    logic [TW-1:0]   w_tnew_dec;
    logic            w_alu_src;
    alu_op_e         w_alu_ctr;

    assign w_load = !flush && !stall;

    // A write to $0 is architecturally discarded, so never advertise it as
    // a forwarding source.
    assign w_regwr = regwr_in & valid_in & (waddr_in != '0);

    // Saturating decrement: results that would go negative clamp at 0
    // (covers TDEC=0 as a plain copy).
    assign w_tnew_dec = (tnew_in > TDEC_W) ? (tnew_in - TDEC_W) : '0;

    // Empty slots carry NOP controls regardless of what op/funct hold.
    assign w_alu_src = valid_in & decode_alu_src(w_flags);
    assign w_alu_ctr = valid_in ? decode_alu_ctr(w_flags) : ALU_ADDU;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [OPW-1:0]   r_op;
    logic [FUNCW-1:0] r_func;
    logic [RAW-1:0]   r_waddr;
    logic             r_regwr;
    logic [TW-1:0]    r_tnew;
    logic             r_alu_src;
    logic [2:0]       r_alu_ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_func    <= '0;
            r_waddr   <= '0;
            r_regwr   <= 1'b0;
            r_tnew    <= '0;
            r_alu_src <= 1'b0;
            r_alu_ctr <= ALU_ADDU;
        end else if (flush) begin
            // Bubble wins even when the stage is stalled
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_func    <= '0;
            r_waddr   <= '0;
            r_regwr   <= 1'b0;
            r_tnew    <= '0;
            r_alu_src <= 1'b0;
            r_alu_ctr <= ALU_ADDU;
        end else if (w_load) begin
            r_valid   <= valid_in;
            r_op      <= op_in;
            r_func    <= func_in;
            r_waddr   <= waddr_in;
            r_regwr   <= w_regwr;
            r_tnew    <= w_tnew_dec;
            r_alu_src <= w_alu_src;
            r_alu_ctr <= w_alu_ctr;
        end
        // stall without flush: everything holds, Tnew included
    end

    assign valid_out = r_valid;
    assign op_out    = r_op;
    assign func_out  = r_func;
    assign waddr_out = r_waddr;
    assign regwr_out = r_regwr;
    assign tnew_out  = r_tnew;
    assign alu_src   = r_alu_src;
    assign alu_ctr   = r_alu_ctr;

    assign fwd_ready = r_valid & r_regwr & (r_tnew == '0);

    // ------------------------------------------------------------------
    // Multiply/divide busy tracking
    // ------------------------------------------------------------------
`ifdef PIPE_STAGE_MDU_BUSY_EN
    localparam logic [4:0] MDU_LAT_W = 5'(MDU_LAT);

    logic       w_mdu_start;
    logic [4:0] r_mdu_cnt;

    assign w_mdu_start = w_load & valid_in & decode_is_mdu(w_flags);

    // The counter models the MDU itself, not the stage slot, so it keeps
    // counting through stalls and is not cleared by a flush. A new MDU
    // instruction restarts the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (w_mdu_start) begin
            r_mdu_cnt <= MDU_LAT_W;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - 5'd1;
        end
    end

    assign mdu_busy = (r_mdu_cnt != '0);

    logic w_unused_flags;
    assign w_unused_flags = ^w_flags;
`else
    assign mdu_busy = 1'b0;

    // Flag bits and MDU_LAT only matter for the busy counter build
    logic w_unused_flags;
    assign w_unused_flags = ^{w_flags, 32'(MDU_LAT)};
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, flush, valid_in;
    logic [5:0] op_in, func_in;
    logic [4:0] waddr_in;
    logic       regwr_in;
    logic [1:0] tnew_in;
    logic       valid_out;
    logic [5:0] op_out, func_out;
    logic [4:0] waddr_out;
    logic       regwr_out;
    logic [1:0] tnew_out;
    logic       alu_src;
    logic [2:0] alu_ctr;
    logic       fwd_ready;
    logic       mdu_busy;

    pipe_stage_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .valid_in  (valid_in),
        .op_in     (op_in),
        .func_in   (func_in),
        .waddr_in  (waddr_in),
        .regwr_in  (regwr_in),
        .tnew_in   (tnew_in),
        .valid_out (valid_out),
        .op_out    (op_out),
        .func_out  (func_out),
        .waddr_out (waddr_out),
        .regwr_out (regwr_out),
        .tnew_out  (tnew_out),
        .alu_src   (alu_src),
        .alu_ctr   (alu_ctr),
        .fwd_ready (fwd_ready),
        .mdu_busy  (mdu_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] wa;
        logic       rw;
        logic [1:0] tn;
        logic       src;
        logic [2:0] ctr;
        logic       fwd;
        logic       mdu;
    } obs_t;

    typedef struct {
        int    tag;
        string name;
        obs_t  exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic obs_t mk(input logic v, input logic [5:0] op,
                                input logic [5:0] fn, input logic [4:0] wa,
                                input logic rw, input logic [1:0] tn,
                                input logic src, input logic [2:0] ctr,
                                input logic mdu);
        obs_t o;
        o.v   = v;
        o.op  = op;
        o.fn  = fn;
        o.wa  = wa;
        o.rw  = rw;
        o.tn  = tn;
        o.src = src;
        o.ctr = ctr;
        o.fwd = v & rw & (tn == 2'd0);
        o.mdu = mdu;
        return o;
    endfunction

    task automatic drive(input logic s, input logic f, input logic v,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] wa, input logic rw,
                         input logic [1:0] tn);
        stall    = s;
        flush    = f;
        valid_in = v;
        op_in    = op;
        func_in  = fn;
        waddr_in = wa;
        regwr_in = rw;
        tnew_in  = tn;
    endtask

    task automatic sb_push(input int tag, input string nm, input obs_t e);
        sb_t t;
        t.tag  = tag;
        t.name = nm;
        t.exp  = e;
        sb_q.push_back(t);
    endtask

    task automatic step(input string nm, input logic s, input logic f,
                        input logic v, input logic [5:0] op,
                        input logic [5:0] fn, input logic [4:0] wa,
                        input logic rw, input logic [1:0] tn, input obs_t e);
        @(posedge clk);
        #1;
        drive(s, f, v, op, fn, wa, rw, tn);
        sb_push(cyc + 1, nm, e);
    endtask

    always @(negedge clk) begin
        obs_t act;
        sb_t  e;
        act = {valid_out, op_out, func_out, waddr_out, regwr_out, tnew_out,
               alu_src, alu_ctr, fwd_ready, mdu_busy};
        while (sb_q.size() > 0 && sb_q[0].tag < cyc) begin
            e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s not sampled: due cycle %0d, now %0d", e.name, e.tag, cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].tag == cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%h required=%h (v op fn wa rw tn src ctr fwd mdu)",
                         e.name, cyc, act, e.exp);
            end else begin
                $display("ok   %s cyc=%0d out=%h", e.name, cyc, act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero, ori5;
        obs_t act_now;
        int   t;
        zero = mk(0, 6'h00, 6'h00, 5'd0, 0, 2'd0, 0, 3'd0, 0);
        ori5 = mk(1, 6'h0D, 6'h11, 5'd5, 1, 2'd0, 1, 3'd2, 0);

        rst_n = 1'b0;
        drive(0, 0, 1, 6'h23, 6'h05, 5'd8, 1, 2'd2);
        sb_push(1, "reset_c1", zero);
        sb_push(2, "reset_c2", zero);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0);
        sb_push(cyc + 1, "post_release_idle", zero);

        step("lw_t2", 0, 0, 1, 6'h23, 6'h05, 5'd8, 1, 2'd2,
             mk(1, 6'h23, 6'h05, 5'd8, 1, 2'd1, 1, 3'd0, 0));
        step("lw_t0_sat", 0, 0, 1, 6'h23, 6'h05, 5'd8, 1, 2'd0,
             mk(1, 6'h23, 6'h05, 5'd8, 1, 2'd0, 1, 3'd0, 0));

        step("ori_load", 0, 0, 1, 6'h0D, 6'h11, 5'd5, 1, 2'd1, ori5);
        step("stall1", 1, 0, 1, 6'h00, 6'h23, 5'd9, 1, 2'd2, ori5);
        step("stall2", 1, 0, 1, 6'h0F, 6'h00, 5'd7, 1, 2'd3, ori5);
        step("stall3", 1, 0, 0, 6'h2B, 6'h3F, 5'd31, 0, 2'd0, ori5);

        step("flush_over_stall", 1, 1, 1, 6'h00, 6'h23, 5'd9, 1, 2'd2, zero);

        step("addu_r0", 0, 0, 1, 6'h00, 6'h21, 5'd0, 1, 2'd1,
             mk(1, 6'h00, 6'h21, 5'd0, 0, 2'd0, 0, 3'd0, 0));
        step("invalid_addu", 0, 0, 0, 6'h00, 6'h21, 5'd4, 1, 2'd2,
             mk(0, 6'h00, 6'h21, 5'd4, 0, 2'd1, 0, 3'd0, 0));

        step("subu", 0, 0, 1, 6'h00, 6'h23, 5'd9, 1, 2'd2,
             mk(1, 6'h00, 6'h23, 5'd9, 1, 2'd1, 0, 3'd1, 0));
        step("lui_t3", 0, 0, 1, 6'h0F, 6'h00, 5'd7, 1, 2'd3,
             mk(1, 6'h0F, 6'h00, 5'd7, 1, 2'd2, 1, 3'd3, 0));
        step("sw", 0, 0, 1, 6'h2B, 6'h00, 5'd10, 0, 2'd0,
             mk(1, 6'h2B, 6'h00, 5'd10, 0, 2'd0, 1, 3'd0, 0));
        step("unknown_op", 0, 0, 1, 6'h3F, 6'h3F, 5'd1, 1, 2'd1,
             mk(1, 6'h3F, 6'h3F, 5'd1, 1, 2'd0, 0, 3'd0, 0));
        step("beq", 0, 0, 1, 6'h04, 6'h00, 5'd0, 0, 2'd0,
             mk(1, 6'h04, 6'h00, 5'd0, 0, 2'd0, 0, 3'd0, 0));
        step("invalid_ori", 0, 0, 0, 6'h0D, 6'h11, 5'd5, 1, 2'd1,
             mk(0, 6'h0D, 6'h11, 5'd5, 0, 2'd0, 0, 3'd0, 0));
        step("flush_only", 0, 1, 1, 6'h23, 6'h05, 5'd8, 1, 2'd2, zero);

`ifdef PIPE_STAGE_MDU_BUSY_EN
        step("mult_a", 0, 0, 1, 6'h00, 6'h18, 5'd0, 0, 2'd1,
             mk(1, 6'h00, 6'h18, 5'd0, 0, 2'd0, 0, 3'd0, 1));
        step("busy_a4", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_a3", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_a2", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_a1", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_a0", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, zero);
        step("mult_b", 0, 0, 1, 6'h00, 6'h18, 5'd0, 0, 2'd1,
             mk(1, 6'h00, 6'h18, 5'd0, 0, 2'd0, 0, 3'd0, 1));
        step("busy_b4", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_b3", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_b2", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("divu_reload", 0, 0, 1, 6'h00, 6'h1B, 5'd0, 0, 2'd1,
             mk(1, 6'h00, 6'h1B, 5'd0, 0, 2'd0, 0, 3'd0, 1));
        step("flush_busy4", 0, 1, 1, 6'h00, 6'h21, 5'd3, 1, 2'd1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("stall_busy3", 1, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_c2", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_c1", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("busy_c0", 0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 2'd0, zero);
`else
        step("mult_no_busy", 0, 0, 1, 6'h00, 6'h18, 5'd0, 0, 2'd1,
             mk(1, 6'h00, 6'h18, 5'd0, 0, 2'd0, 0, 3'd0, 0));
`endif

        @(posedge clk);
        #1;
        drive(0, 0, 1, 6'h00, 6'h21, 5'd3, 1, 2'd2);
        t = cyc;
        sb_push(t + 1, "reset_async", zero);
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1 || waddr_out !== 5'd3 || regwr_out !== 1'b1 ||
            tnew_out !== 2'd1) begin
            failures++;
            $display("FAIL addu_loaded_before_reset v=%b wa=%0d rw=%b tn=%0d",
                     valid_out, waddr_out, regwr_out, tnew_out);
        end else begin
            $display("ok   addu_loaded_before_reset v=%b wa=%0d rw=%b tn=%0d",
                     valid_out, waddr_out, regwr_out, tnew_out);
        end
        rst_n = 1'b0;
        #1;
        act_now = {valid_out, op_out, func_out, waddr_out, regwr_out, tnew_out,
                   alu_src, alu_ctr, fwd_ready, mdu_busy};
        checks++;
        if (act_now !== zero) begin
            failures++;
            $display("FAIL reset_immediate actual=%h required=%h", act_now, zero);
        end else begin
            $display("ok   reset_immediate out=%h", act_now);
        end
        sb_push(t + 2, "reset_hold", zero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_push(t + 3, "reset_reload",
                mk(1, 6'h00, 6'h21, 5'd3, 1, 2'd1, 0, 3'd0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
